// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-requester round-robin bus arbiter with timeout
// Core (requester 0) and debug SBA (requester 1) share one memory bus.
module bus_arbiter #(
   parameter int AddrWidth = 32,
   parameter int DataWidth = 32,
   parameter int Timeout   = 255
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 m0_rd,
   input  logic                 m0_wr,
   input  logic [AddrWidth-1:0] m0_addr,
   input  logic [DataWidth-1:0] m0_wdata,
   input  logic [2:0]           m0_size,
   output logic [DataWidth-1:0] m0_rdata,
   output logic                 m0_done,
   output logic                 m0_err,
   input  logic                 m1_rd,
   input  logic                 m1_wr,
   input  logic [AddrWidth-1:0] m1_addr,
   input  logic [DataWidth-1:0] m1_wdata,
   input  logic [2:0]           m1_size,
   output logic [DataWidth-1:0] m1_rdata,
   output logic                 m1_done,
   output logic                 m1_err,
   output logic                 bus_rd,
   output logic                 bus_wr,
   output logic [AddrWidth-1:0] bus_addr,
   output logic [DataWidth-1:0] bus_wdata,
   output logic [2:0]           bus_size,
   input  logic [DataWidth-1:0] bus_rdata,
   input  logic                 bus_done,
   output logic [1:0]           grant
);

   localparam int CntWidth = $clog2(Timeout + 1);
   localparam logic [CntWidth-1:0] TimeoutVal = CntWidth'(Timeout);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t                state, state_next;
   logic                  last;
   logic [CntWidth-1:0]   cnt, cnt_inc;
   logic                  lat_rd, lat_wr, err_flag;
   logic [AddrWidth-1:0]  lat_addr;
   logic [DataWidth-1:0]  lat_wdata;
   logic [2:0]            lat_size;

   logic                  req0, req1, any_req, winner, timed_out, illegal;
   logic                  win_rd, win_wr;
   logic [AddrWidth-1:0]  win_addr;
   logic [DataWidth-1:0]  win_wdata;
   logic [2:0]            win_size;

   assign req0    = m0_rd | m0_wr;
   assign req1    = m1_rd | m1_wr;
   assign any_req = req0 | req1;
   // On a tie the requester not served last wins; otherwise whoever asks.
   assign winner  = (req0 & req1) ? ~last : req1;

   assign win_rd    = winner ? m1_rd    : m0_rd;
   assign win_wr    = winner ? m1_wr    : m0_wr;
   assign win_addr  = winner ? m1_addr  : m0_addr;
   assign win_wdata = winner ? m1_wdata : m0_wdata;
   assign win_size  = winner ? m1_size  : m0_size;
   assign illegal   = win_rd & win_wr;

   assign cnt_inc   = (cnt == TimeoutVal) ? cnt : cnt + 1'b1;
   assign timed_out = (cnt_inc == TimeoutVal);

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (any_req) state_next = illegal ? RESP : BUSY;
         BUSY: if (bus_done || timed_out) state_next = RESP;
         RESP: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant     <= 2'b00;
         last      <= 1'b1;
         cnt       <= '0;
         lat_rd    <= 1'b0;
         lat_wr    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_size  <= '0;
         err_flag  <= 1'b0;
         m0_rdata  <= '0;
         m1_rdata  <= '0;
      end else begin
         case (state)
            IDLE: if (any_req) begin
               lat_rd    <= win_rd;
               lat_wr    <= win_wr;
               lat_addr  <= win_addr;
               lat_wdata <= win_wdata;
               lat_size  <= win_size;
               grant     <= winner ? 2'b10 : 2'b01;
               last      <= winner;
               cnt       <= '0;
               err_flag  <= illegal;
               if (illegal) begin
                  if (winner) m1_rdata <= '0;
                  else        m0_rdata <= '0;
               end
            end
            BUSY: begin
               // bus_done takes priority over a simultaneous timeout
               if (bus_done) begin
                  err_flag <= 1'b0;
                  if (grant[1]) m1_rdata <= bus_rdata;
                  else          m0_rdata <= bus_rdata;
               end else begin
                  cnt <= cnt_inc;
                  if (timed_out) begin
                     err_flag <= 1'b1;
                     if (grant[1]) m1_rdata <= '0;
                     else          m0_rdata <= '0;
                  end
               end
            end
            RESP: grant <= 2'b00;
            default: grant <= 2'b00;
         endcase
      end
   end

   assign bus_rd    = (state == BUSY) & lat_rd;
   assign bus_wr    = (state == BUSY) & lat_wr;
   assign bus_addr  = lat_addr;
   assign bus_wdata = lat_wdata;
   assign bus_size  = lat_size;

   assign m0_done = (state == RESP) & grant[0];
   assign m1_done = (state == RESP) & grant[1];
   assign m0_err  = m0_done & err_flag;
   assign m1_err  = m1_done & err_flag;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - self-checking bench for bus_arbiter
// Directed scenarios followed by randomized transactions against a transaction-level model.
module tb_bus_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          m0_rd = 0, m0_wr = 0, m1_rd = 0, m1_wr = 0;
   logic [AW-1:0] m0_addr = 0, m1_addr = 0;
   logic [DW-1:0] m0_wdata = 0, m1_wdata = 0;
   logic [2:0]    m0_size = 0, m1_size = 0;
   logic [DW-1:0] m0_rdata, m1_rdata;
   logic          m0_done, m0_err, m1_done, m1_err;
   logic          bus_rd, bus_wr;
   logic [AW-1:0] bus_addr;
   logic [DW-1:0] bus_wdata;
   logic [2:0]    bus_size;
   logic [DW-1:0] bus_rdata = 0;
   logic          bus_done = 0;
   logic [1:0]    grant;

   int total = 0;
   int bad = 0;

   bus_arbiter #(.AddrWidth(AW), .DataWidth(DW), .Timeout(TO)) dut (
      .clk(clk), .rst(rst),
      .m0_rd(m0_rd), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_size(m0_size),
      .m0_rdata(m0_rdata), .m0_done(m0_done), .m0_err(m0_err),
      .m1_rd(m1_rd), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_size(m1_size),
      .m1_rdata(m1_rdata), .m1_done(m1_done), .m1_err(m1_err),
      .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_size(bus_size), .bus_rdata(bus_rdata), .bus_done(bus_done), .grant(grant)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(negedge clk);
   endtask

   task automatic test_reset();
      #2;
      total++; if (grant !== 2'b00) begin bad++; $display("FAIL reset_grant got=%b want=00", grant); end
      total++; if ({bus_rd, bus_wr} !== 2'b00) begin bad++; $display("FAIL reset_strobes got=%b want=00", {bus_rd, bus_wr}); end
      total++; if ({m0_done, m0_err, m1_done, m1_err} !== 4'b0) begin bad++; $display("FAIL reset_done_err got=%b want=0000", {m0_done, m0_err, m1_done, m1_err}); end
      total++; if (m0_rdata !== 0 || m1_rdata !== 0) begin bad++; $display("FAIL reset_rdata got=%h/%h want=0/0", m0_rdata, m1_rdata); end
      step();
      rst = 1'b0;
   endtask

   task automatic test_single_read();
      m0_rd = 1; m0_addr = 32'h100; m0_size = 3'b010;
      step();
      total++; if (grant !== 2'b01 || bus_rd !== 1'b1 || bus_addr !== 32'h100) begin bad++; $display("FAIL single_busy got grant=%b rd=%b addr=%h want 01/1/100", grant, bus_rd, bus_addr); end
      step();
      step();
      bus_done = 1; bus_rdata = 32'hDEADBEEF;
      step();
      total++; if (m0_done !== 1'b1 || m0_err !== 1'b0 || m0_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL single_resp got done=%b err=%b rdata=%h want 1/0/deadbeef", m0_done, m0_err, m0_rdata); end
      total++; if (bus_rd !== 1'b0 || m1_done !== 1'b0) begin bad++; $display("FAIL single_resp_side got rd=%b m1_done=%b want 0/0", bus_rd, m1_done); end
      bus_done = 0; m0_rd = 0;
      step();
      total++; if (m0_done !== 1'b0 || grant !== 2'b00 || m0_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL single_idle got done=%b grant=%b rdata=%h want 0/00/deadbeef", m0_done, grant, m0_rdata); end
   endtask

   task automatic test_tie();
      rst = 1; step(); rst = 0;
      m0_rd = 1; m0_addr = 32'h10; m1_wr = 1; m1_addr = 32'h20; m1_wdata = 32'h5555;
      step();
      total++; if (grant !== 2'b01 || bus_rd !== 1'b1) begin bad++; $display("FAIL tie_first got grant=%b rd=%b want 01/1", grant, bus_rd); end
      bus_done = 1; bus_rdata = 32'hA0A0;
      step();
      total++; if (m0_done !== 1'b1 || m1_done !== 1'b0) begin bad++; $display("FAIL tie_first_done got m0=%b m1=%b want 1/0", m0_done, m1_done); end
      bus_done = 0; m0_rd = 0;
      step();
      total++; if (grant !== 2'b00 || {bus_rd, bus_wr} !== 2'b00) begin bad++; $display("FAIL tie_gap got grant=%b strobes=%b want 00/00", grant, {bus_rd, bus_wr}); end
      step();
      total++; if (grant !== 2'b10 || bus_wr !== 1'b1 || bus_addr !== 32'h20 || bus_wdata !== 32'h5555) begin bad++; $display("FAIL tie_second got grant=%b wr=%b addr=%h wdata=%h want 10/1/20/5555", grant, bus_wr, bus_addr, bus_wdata); end
      bus_done = 1; bus_rdata = 32'hB1B1;
      step();
      total++; if (m1_done !== 1'b1 || m1_rdata !== 32'hB1B1 || m0_rdata !== 32'hA0A0 || m0_done !== 1'b0) begin bad++; $display("FAIL tie_second_done got done=%b rdata=%h hold=%h want 1/b1b1/a0a0", m1_done, m1_rdata, m0_rdata); end
      bus_done = 0; m1_wr = 0;
      step();
   endtask

   task automatic test_round_robin();
      logic [1:0] want [3];
      want[0] = 2'b01; want[1] = 2'b10; want[2] = 2'b01;
      m0_rd = 1; m1_rd = 1;
      for (int t = 0; t < 3; t++) begin
         step();
         total++; if (grant !== want[t]) begin bad++; $display("FAIL rr_grant_%0d got=%b want=%b", t, grant, want[t]); end
         bus_done = 1; bus_rdata = 32'hC000 + t;
         step();
         bus_done = 0;
         if (t == 2) begin m0_rd = 0; m1_rd = 0; end
         step();
      end
   endtask

   task automatic test_timeout();
      int busy = 0;
      m1_rd = 1; m1_addr = 32'h300;
      step();
      for (int k = 0; k < 10; k++) begin
         if (!bus_rd) break;
         busy++;
         step();
      end
      total++; if (busy != TO) begin bad++; $display("FAIL timeout_len got=%0d want=%0d", busy, TO); end
      total++; if (m1_done !== 1'b1 || m1_err !== 1'b1 || m1_rdata !== 0) begin bad++; $display("FAIL timeout_resp got done=%b err=%b rdata=%h want 1/1/0", m1_done, m1_err, m1_rdata); end
      m1_rd = 0;
      bus_done = 1;
      step();
      step();
      total++; if (grant !== 2'b00 || {m0_done, m1_done} !== 2'b00) begin bad++; $display("FAIL idle_ignores_done got grant=%b done=%b want 00/00", grant, {m0_done, m1_done}); end
      bus_done = 0;
   endtask

   task automatic test_illegal();
      m0_rd = 1; m0_wr = 1;
      step();
      total++; if (m0_done !== 1'b1 || m0_err !== 1'b1 || m0_rdata !== 0 || grant !== 2'b01) begin bad++; $display("FAIL illegal_resp got done=%b err=%b rdata=%h grant=%b want 1/1/0/01", m0_done, m0_err, m0_rdata, grant); end
      total++; if ({bus_rd, bus_wr} !== 2'b00) begin bad++; $display("FAIL illegal_strobe got=%b want=00", {bus_rd, bus_wr}); end
      m0_rd = 0; m0_wr = 0;
      step();
      total++; if (m0_done !== 1'b0) begin bad++; $display("FAIL illegal_after got=%b want=0", m0_done); end
   endtask

   task automatic test_reset_mid();
      m0_wr = 1; m0_addr = 32'h400;
      step();
      total++; if (bus_wr !== 1'b1) begin bad++; $display("FAIL rstmid_busy got=%b want=1", bus_wr); end
      #1 rst = 1;
      #1;
      total++; if (bus_wr !== 1'b0 || grant !== 2'b00 || m0_done !== 1'b0) begin bad++; $display("FAIL rstmid_async got wr=%b grant=%b done=%b want 0/00/0", bus_wr, grant, m0_done); end
      step();
      rst = 0; m0_wr = 0;
      step();
      total++; if (m0_done !== 1'b0 || grant !== 2'b00) begin bad++; $display("FAIL rstmid_idle got done=%b grant=%b want 0/00", m0_done, grant); end
      m0_rd = 1; m1_rd = 1;
      step();
      total++; if (grant !== 2'b01) begin bad++; $display("FAIL rstmid_last got=%b want=01", grant); end
      bus_done = 1;
      step();
      bus_done = 0; m0_rd = 0; m1_rd = 0;
      step();
   endtask

   task automatic drive_req(input int i, input logic rd, input logic wr,
                            input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [2:0] s);
      if (i == 0) begin m0_rd = rd; m0_wr = wr; m0_addr = a; m0_wdata = d; m0_size = s; end
      else        begin m1_rd = rd; m1_wr = wr; m1_addr = a; m1_wdata = d; m1_size = s; end
   endtask

   task automatic test_random(input int rounds);
      logic          pend [2];
      logic          q_rd [2];
      logic          q_wr [2];
      logic [AW-1:0] q_addr [2];
      logic [DW-1:0] q_wdata [2];
      logic [2:0]    q_size [2];
      logic [DW-1:0] exp_rdata [2];
      logic          mdl_last;
      rst = 1; step(); rst = 0;
      mdl_last = 1'b1;
      exp_rdata[0] = 0; exp_rdata[1] = 0;
      for (int r = 0; r < rounds; r++) begin
         pend[0] = ($urandom % 3) != 0;
         pend[1] = ($urandom % 3) != 0;
         if (!pend[0] && !pend[1]) pend[$urandom % 2] = 1'b1;
         for (int i = 0; i < 2; i++) begin
            int kind = $urandom % 5;
            q_rd[i]    = (kind < 2) || (kind == 4);
            q_wr[i]    = (kind >= 2);
            q_addr[i]  = $urandom;
            q_wdata[i] = $urandom;
            q_size[i]  = 3'($urandom);
            if (pend[i]) drive_req(i, q_rd[i], q_wr[i], q_addr[i], q_wdata[i], q_size[i]);
         end
         while (pend[0] || pend[1]) begin
            int w;
            logic [1:0] oh;
            logic [1:0] dn;
            logic       er;
            logic       exp_err;
            w = (pend[0] && pend[1]) ? int'(!mdl_last) : (pend[1] ? 1 : 0);
            mdl_last = (w == 1);
            oh = (w == 1) ? 2'b10 : 2'b01;
            step();
            total++; if (grant !== oh) begin bad++; $display("FAIL rnd_grant r=%0d got=%b want=%b", r, grant, oh); end
            if (q_rd[w] && q_wr[w]) begin
               exp_err = 1'b1;
               exp_rdata[w] = 0;
               total++; if ({bus_rd, bus_wr} !== 2'b00) begin bad++; $display("FAIL rnd_illegal_strobe r=%0d got=%b want=00", r, {bus_rd, bus_wr}); end
            end else begin
               int d = $urandom % 6;
               int busy = 0;
               int exp_busy = (d + 1 <= TO) ? d + 1 : TO;
               logic [DW-1:0] data = $urandom;
               exp_err = (d + 1 > TO);
               exp_rdata[w] = exp_err ? '0 : data;
               total++; if (bus_rd !== q_rd[w] || bus_wr !== q_wr[w] || bus_addr !== q_addr[w] || bus_wdata !== q_wdata[w] || bus_size !== q_size[w]) begin
                  bad++; $display("FAIL rnd_bus r=%0d got rd=%b wr=%b a=%h d=%h s=%0d want %b/%b/%h/%h/%0d", r, bus_rd, bus_wr, bus_addr, bus_wdata, bus_size, q_rd[w], q_wr[w], q_addr[w], q_wdata[w], q_size[w]);
               end
               for (int k = 0; k < 12; k++) begin
                  if (!(bus_rd || bus_wr)) break;
                  busy++;
                  if (k == d) begin bus_done = 1; bus_rdata = data; end
                  step();
                  bus_done = 0;
               end
               total++; if (busy != exp_busy) begin bad++; $display("FAIL rnd_busy_len r=%0d got=%0d want=%0d", r, busy, exp_busy); end
            end
            dn = {m1_done, m0_done};
            er = (w == 1) ? m1_err : m0_err;
            total++; if (dn !== oh || er !== exp_err) begin bad++; $display("FAIL rnd_resp r=%0d got done=%b err=%b want %b/%b", r, dn, er, oh, exp_err); end
            total++; if (m0_rdata !== exp_rdata[0] || m1_rdata !== exp_rdata[1]) begin bad++; $display("FAIL rnd_rdata r=%0d got=%h/%h want=%h/%h", r, m0_rdata, m1_rdata, exp_rdata[0], exp_rdata[1]); end
            drive_req(w, 1'b0, 1'b0, '0, '0, '0);
            pend[w] = 1'b0;
            step();
            total++; if (grant !== 2'b00 || {bus_rd, bus_wr} !== 2'b00) begin bad++; $display("FAIL rnd_gap r=%0d got grant=%b strobes=%b want 00/00", r, grant, {bus_rd, bus_wr}); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_tie();
      test_round_robin();
      test_timeout();
      test_illegal();
      test_reset_mid();
      test_random(60);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
